product_accumulator: RTL and testbench
======================================

# product_accumulator

Sequential accumulation stage placed directly downstream of the generated `multiplier` (`mult.u1`). It accepts unsigned products one per cycle over a valid/ready handshake, sums a group of products terminated by `in_last` or by a term-count limit, and presents the group total on a registered valid/ready output. It is the accumulate half of the team's multiply-accumulate datapath.

## Interface
- `a_width`, 8: multiplier operand A width; matches the upstream `multiplier`.
- `b_width`, 8: multiplier operand B width; matches the upstream `multiplier`.
- `acc_width`, 24: accumulator width. Must be ≥ `a_width+b_width`; elaboration error otherwise.
- `max_terms`, 16: maximum products per group (≥1).
- Localparams, not overridable: `product_width = a_width+b_width`; `cnt_width = $clog2(max_terms+1)`.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  product beat valid.
- `in_ready`  out  1  stage can accept a beat.
- `in_product`  in  `product_width`  unsigned product from `multiplier`.
- `in_last`  in  1  beat closes the current group.
- `out_valid`  out  1  group result valid.
- `out_ready`  in  1  consumer accepts the result.
- `out_sum`  out  `acc_width`  group total.
- `out_count`  out  `cnt_width`  number of products in the group (1..`max_terms`).
- `out_ovf`  out  1  sticky: the total exceeded 2^`acc_width`−1 at some point in the group.

## Operation
- Two states: ACCUM and HOLD. Reset state is ACCUM.
- ACCUM:
  - `in_ready`=1 and `out_valid`=0.
  - A beat is accepted when `in_valid && in_ready`. On accept: `sum <= sum + in_product`, computed `acc_width+1` wide; `count <= count+1`.
  - If the carry bit is set, `ovf <= 1`.
  - Move to HOLD when the accepted beat has `in_last`=1 or `count+1 == max_terms`. The term limit forces the group to close even without `in_last`.
- HOLD:
  - `in_ready`=0 and `out_valid`=1.
  - `out_sum`, `out_count` and `out_ovf` are stable until the result is accepted.
  - When `out_ready`=1: clear `sum`, `count` and `ovf` to 0 and return to ACCUM.
- `in_last` is ignored unless the beat is accepted.
- All arithmetic is unsigned. The product is zero-extended to `acc_width`.
- The outputs are driven directly from the `sum`, `count` and `ovf` registers.

## Timing
- Reset values: `in_ready`=0 during the cycle `rst` is sampled high. After reset, `in_ready`=1.
- Reset values of the remaining outputs: `out_valid`=0, `out_sum`=0, `out_count`=0, `out_ovf`=0.
- `rst` asserted in any state, including mid-group or in HOLD, discards all partial state on that edge. No result is emitted for the aborted group.
- Latency: `out_valid` rises on the cycle after the closing beat is accepted.
- Throughput: one beat per cycle within a group. Each group costs at least one HOLD cycle, during which `in_ready`=0. There is no skid buffer; the upstream must hold `in_product` while `in_ready`=0.
- `out_ready` is ignored in ACCUM. `in_valid` is ignored in HOLD.
- Handshake rule: `in_ready` depends only on state, never on `in_valid`. `out_valid`, once high, stays high until it is accepted.
- A group of a single beat with `in_last`=1 is legal: `out_count`=1.

## Configuration
- `PRODUCT_ACC_SAT_EN` defined:
  - On carry-out, `sum` clamps to all-ones (2^`acc_width`−1) and stays clamped for the rest of the group.
  - `ovf` is set.
- `PRODUCT_ACC_SAT_EN` undefined:
  - `sum` wraps modulo 2^`acc_width`.
  - `ovf` is still set on any carry-out.
- Both builds: handshake, state machine and timing are identical.

## Test plan
- Default parameters: products 3, 5, 7, with `in_last` on 7, and `out_ready`=1. Required: `out_valid` for exactly 1 cycle, one cycle after the beat 7 is accepted, with `out_sum`=15, `out_count`=3, `out_ovf`=0.
- Default parameters: 16 beats of 1000 with no `in_last`. Required: the group closes on the 16th beat with `out_sum`=16000 and `out_count`=16. The next beat starts a new group with `sum`=0.
- `acc_width`=16: 0xFFFF then 0x0002 with `in_last`.
  - With `PRODUCT_ACC_SAT_EN` defined: `out_sum`=0xFFFF, `out_ovf`=1.
  - Without it: `out_sum`=0x0001, `out_ovf`=1.
- Backpressure: hold `out_ready`=0 for 5 cycles in HOLD while `in_valid`=1. Required:
  - `in_ready`=0 and the outputs are stable throughout.
  - `out_ready` then rises: `in_ready`=1 on the next cycle and the pending `in_product` is accepted into the new group.
- Reset mid-group: accept 2 beats (10, 20), then assert `rst` for one cycle, then send 4 with `in_last`. Required: `out_sum`=4, `out_count`=1.
- Single-beat groups back-to-back with `out_ready`=1. Required: an accept/result pattern every 2 cycles, and `out_count`=1 for every result.

Source files
------------

// File: rtl/product_accumulator.sv
// Accumulates a group of unsigned products (closed by in_last or the term limit) and presents the group total.
// Optional build macro: PRODUCT_ACC_SAT_EN clamps the running sum to all-ones on overflow instead of wrapping.
module product_accumulator #(
  parameter  int unsigned a_width       = 8,
  parameter  int unsigned b_width       = 8,
  parameter  int unsigned acc_width     = 24,
  parameter  int unsigned max_terms     = 16,
  localparam int unsigned product_width = a_width + b_width,
  localparam int unsigned cnt_width     = $clog2(max_terms + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [product_width-1:0] in_product,
  input  logic                     in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [acc_width-1:0]     out_sum,
  output logic [cnt_width-1:0]     out_count,
  output logic                     out_ovf
);

  localparam int unsigned sum_w = acc_width + 1;

  if (acc_width < product_width) begin : g_bad_acc_width
    $error("product_accumulator: acc_width must be >= a_width + b_width");
  end
  if (max_terms < 1) begin : g_bad_max_terms
    $error("product_accumulator: max_terms must be >= 1");
  end

  typedef enum logic {ACCUM, HOLD} state_t;

  state_t               state, state_next;
  logic [acc_width-1:0] sum, sum_next;
  logic [cnt_width-1:0] count, count_next;
  logic                 ovf, ovf_next;
  logic [sum_w-1:0]     sum_wide;

  // Next-state and datapath update; the carry bit of sum_wide flags overflow.
  always_comb begin
    state_next = state;
    sum_next   = sum;
    count_next = count;
    ovf_next   = ovf;
    sum_wide   = {1'b0, sum} + sum_w'(in_product);
    case (state)
      ACCUM: begin
        if (in_valid && in_ready) begin
          count_next = count + cnt_width'(1);
          sum_next   = sum_wide[acc_width-1:0];
          if (sum_wide[acc_width]) begin
            ovf_next = 1'b1;
`ifdef PRODUCT_ACC_SAT_EN
            sum_next = '1;
`endif
          end
          if (in_last || (count_next == cnt_width'(max_terms))) begin
            state_next = HOLD;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          sum_next   = '0;
          count_next = '0;
          ovf_next   = 1'b0;
          state_next = ACCUM;
        end
      end
      default: state_next = ACCUM;
    endcase
  end

  // Handshake flags are registered copies of the next state so they never depend on in_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ACCUM;
      sum       <= '0;
      count     <= '0;
      ovf       <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_next;
      sum       <= sum_next;
      count     <= count_next;
      ovf       <= ovf_next;
      in_ready  <= (state_next == ACCUM);
      out_valid <= (state_next == HOLD);
    end
  end

  assign out_sum   = sum;
  assign out_count = count;
  assign out_ovf   = ovf;

endmodule

// File: tb/tb_product_accumulator.sv
// Self-checking bench: a 24-bit and a 16-bit accumulator share one stimulus stream and are checked
// against group totals computed with plain integer arithmetic.
module tb_product_accumulator;

`ifdef PRODUCT_ACC_SAT_EN
  localparam bit sat = 1'b1;
`else
  localparam bit sat = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [15:0] in_product;
  logic        in_last;
  logic        out_ready;
  logic        in_ready, in_ready16;
  logic        out_valid, out_valid16;
  logic [23:0] out_sum;
  logic [15:0] out_sum16;
  logic [4:0]  out_count, out_count16;
  logic        out_ovf, out_ovf16;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  product_accumulator u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_product(in_product),
    .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_count(out_count), .out_ovf(out_ovf)
  );

  product_accumulator #(.acc_width(16)) u_dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready16), .in_product(in_product),
    .in_last(in_last), .out_valid(out_valid16), .out_ready(out_ready), .out_sum(out_sum16),
    .out_count(out_count16), .out_ovf(out_ovf16)
  );

  typedef struct packed {
    logic [4:0]        n;
    logic              use_last;
    logic [15:0][15:0] p;
    logic [23:0]       e24;
    logic [15:0]       e16;
    logic [4:0]        ecnt;
    logic              eovf24;
    logic              eovf16;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic longint exp_sum(input longint total, input int w);
    longint m = (longint'(1) << w) - 1;
    if (total > m) return sat ? m : (total & m);
    return total;
  endfunction

  function automatic longint exp_ovf(input longint total, input int w);
    longint m = (longint'(1) << w) - 1;
    return (total > m) ? 1 : 0;
  endfunction

  // Drive one beat at a negedge, wait (bounded) for in_ready, return at the negedge after acceptance.
  task automatic send_beat(input logic [15:0] p, input logic last);
    int guard = 0;
    in_valid   = 1'b1;
    in_product = p;
    in_last    = last;
    while (!in_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 20) check("beat_timeout", 0, 1);
    @(negedge clk);
  endtask

  task automatic check_result(input string name, input longint e24, input longint e16,
                              input longint ecnt, input longint o24, input longint o16);
    check({name, "_valid"},   out_valid,   1);
    check({name, "_valid16"}, out_valid16, 1);
    check({name, "_sum"},     out_sum,     e24);
    check({name, "_sum16"},   out_sum16,   e16);
    check({name, "_count"},   out_count,   ecnt);
    check({name, "_count16"}, out_count16, ecnt);
    check({name, "_ovf"},     out_ovf,     o24);
    check({name, "_ovf16"},   out_ovf16,   o16);
  endtask

  longint q_tot[$];
  int     q_cnt[$];
  longint tot;
  int     cnt;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_product = '0; in_last = 1'b0; out_ready = 1'b1;

    // Vector table: products, group closing mode, expected results for both widths.
    for (int i = 0; i < 7; i++) vecs[i] = '0;
    vecs[0].n = 3; vecs[0].use_last = 1'b1;
    vecs[0].p[0] = 16'd3; vecs[0].p[1] = 16'd5; vecs[0].p[2] = 16'd7;
    vecs[0].e24 = 24'd15; vecs[0].e16 = 16'd15; vecs[0].ecnt = 5'd3;
    vecs[1].n = 16; vecs[1].use_last = 1'b0;
    for (int i = 0; i < 16; i++) vecs[1].p[i] = 16'd1000;
    vecs[1].e24 = 24'd16000; vecs[1].e16 = 16'd16000; vecs[1].ecnt = 5'd16;
    vecs[2].n = 2; vecs[2].use_last = 1'b1;
    vecs[2].p[0] = 16'hFFFF; vecs[2].p[1] = 16'h0002;
    vecs[2].e24 = 24'h010001; vecs[2].e16 = sat ? 16'hFFFF : 16'h0001; vecs[2].ecnt = 5'd2;
    vecs[2].eovf16 = 1'b1;
    vecs[3].n = 1; vecs[3].use_last = 1'b1; vecs[3].p[0] = 16'd42;
    vecs[3].e24 = 24'd42; vecs[3].e16 = 16'd42; vecs[3].ecnt = 5'd1;
    vecs[4].n = 3; vecs[4].use_last = 1'b1;
    for (int i = 0; i < 3; i++) vecs[4].p[i] = 16'h8000;
    vecs[4].e24 = 24'h018000; vecs[4].e16 = sat ? 16'hFFFF : 16'h8000; vecs[4].ecnt = 5'd3;
    vecs[4].eovf16 = 1'b1;
    vecs[5].n = 2; vecs[5].use_last = 1'b1;
    vecs[5].p[0] = 16'h7FFF; vecs[5].p[1] = 16'h8000;
    vecs[5].e24 = 24'h00FFFF; vecs[5].e16 = 16'hFFFF; vecs[5].ecnt = 5'd2;
    vecs[6].n = 16; vecs[6].use_last = 1'b0;
    for (int i = 0; i < 16; i++) vecs[6].p[i] = 16'hFFFF;
    vecs[6].e24 = 24'h0FFFF0; vecs[6].e16 = sat ? 16'hFFFF : 16'hFFF0; vecs[6].ecnt = 5'd16;
    vecs[6].eovf16 = 1'b1;

    // Reset state.
    @(negedge clk); @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_sum", out_sum, 0);
    check("rst_count", out_count, 0);
    check("rst_ovf", out_ovf, 0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1);

    // Table-driven groups, out_ready held high.
    for (int v = 0; v < 7; v++) begin
      for (int b = 0; b < 32'(vecs[v].n); b++) begin
        send_beat(vecs[v].p[b], vecs[v].use_last && (b == 32'(vecs[v].n) - 1));
      end
      check_result($sformatf("vec%0d", v), vecs[v].e24, vecs[v].e16, vecs[v].ecnt,
                   vecs[v].eovf24, vecs[v].eovf16);
      in_valid = 1'b0;
      @(negedge clk);
      check($sformatf("vec%0d_one_cycle", v), out_valid, 0);
      check($sformatf("vec%0d_ready_back", v), in_ready, 1);
    end

    // Backpressure: result held for several cycles while a new beat waits.
    out_ready = 1'b0;
    send_beat(16'd11, 1'b1);
    in_product = 16'd99;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_in_ready", in_ready, 0);
      check("bp_valid", out_valid, 1);
      check("bp_sum", out_sum, 11);
      check("bp_count", out_count, 1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_ready", in_ready, 1);
    check("bp_release_valid", out_valid, 0);
    @(negedge clk);
    check_result("bp_pending", 99, 99, 1, 0, 0);
    in_valid = 1'b0;
    @(negedge clk);

    // Reset in the middle of a group discards the partial sum.
    send_beat(16'd10, 1'b0);
    send_beat(16'd20, 1'b0);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("midrst_sum", out_sum, 0);
    check("midrst_count", out_count, 0);
    check("midrst_valid", out_valid, 0);
    check("midrst_ready", in_ready, 0);
    rst = 1'b0;
    send_beat(16'd4, 1'b1);
    check_result("midrst_group", 4, 4, 1, 0, 0);
    in_valid = 1'b0;
    @(negedge clk);

    // Back-to-back single-beat groups: accept/result alternate every cycle.
    in_valid = 1'b1; in_last = 1'b1; in_product = 16'd100;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (k % 2 == 0) begin
        check("b2b_valid", out_valid, 1);
        check("b2b_ready", in_ready, 0);
        check("b2b_sum", out_sum, 100 + k / 2);
        check("b2b_count", out_count, 1);
      end else begin
        check("b2b_idle_valid", out_valid, 0);
        check("b2b_idle_ready", in_ready, 1);
        in_product = 16'(100 + (k + 1) / 2);
      end
    end
    in_valid = 1'b0;
    @(negedge clk);

    // Randomized traffic against the group-total model.
    tot = 0; cnt = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      if (out_valid) begin
        if (q_tot.size() == 0) check("rnd_spurious_result", 1, 0);
        else begin
          check("rnd_sum", out_sum, exp_sum(q_tot[0], 24));
          check("rnd_sum16", out_sum16, exp_sum(q_tot[0], 16));
          check("rnd_count", out_count, q_cnt[0]);
          check("rnd_ovf", out_ovf, exp_ovf(q_tot[0], 24));
          check("rnd_ovf16", out_ovf16, exp_ovf(q_tot[0], 16));
        end
      end else if (q_tot.size() != 0) check("rnd_missing_result", 0, 1);
      check("rnd_ready_match", in_ready16, in_ready);
      if (!(in_valid && !in_ready)) begin
        in_valid   = (cyc < 2900) && ($urandom_range(3) != 0);
        in_product = 16'($urandom);
        in_last    = ($urandom_range(5) == 0);
      end
      out_ready = (cyc >= 2900) || ($urandom_range(2) != 0);
      if (out_valid && out_ready && q_tot.size() > 0) begin
        void'(q_tot.pop_front());
        void'(q_cnt.pop_front());
      end
      if (in_valid && in_ready) begin
        tot += longint'(in_product);
        cnt++;
        if (in_last || cnt == 16) begin
          q_tot.push_back(tot);
          q_cnt.push_back(cnt);
          tot = 0;
          cnt = 0;
        end
      end
    end
    check("rnd_drained", q_tot.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
